// File: rtl/serial_xnor_correlator.sv
// -----------------------------------------------------------------------------
// serial_xnor_correlator
//
// Sliding-window bit correlator for sync-word detection. Serial bits are
// shifted into a WIDTH-bit window (window[0] is the newest bit). Each window
// bit is compared against a programmable pattern with XNOR. The number of
// agreeing bits is the score. A match is flagged when the score reaches the
// threshold. Results are registered one cycle after the accepted bit.
//
// Optional feature macro: MATCH_CNT_EN
//   defined   : match_count is a saturating count of cycles where
//               out_valid & match is seen.
//   undefined : the counter is not built and match_count is tied to 0.
//               The port list is the same in both builds.
//
// Parameters
//   WIDTH  window/pattern length in bits (>= 2)
//   CNT_W  width of match_count
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     in_bit is valid this cycle
//   in_bit       serial data bit
//   clear        synchronous flush of window, fill, score and match_count
//   pattern      reference word, sampled on every scoring edge
//   threshold    minimum number of agreeing bits for a match
//   out_valid    one-cycle pulse per scored bit
//   score        number of window bits equal to pattern (holds between results)
//   match        score >= threshold, only high together with out_valid
//   match_count  saturating match counter (0 when MATCH_CNT_EN is undefined)
//
// Handshake: the input side has no back-pressure. A bit is accepted on every
// rising edge where in_valid=1 and clear=0. out_valid is a one-cycle pulse
// with no ready; the consumer must take score/match in that cycle.
// -----------------------------------------------------------------------------
module serial_xnor_correlator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_bit,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           pattern,
  input  logic [$clog2(WIDTH+1)-1:0] threshold,
  output logic                       out_valid,
  output logic [$clog2(WIDTH+1)-1:0] score,
  output logic                       match,
  output logic [CNT_W-1:0]           match_count
);

  localparam int TW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The FSM state register is kept as a named signal so that checkers can
  // bind to serial_xnor_correlator.state_q.
  state_t           state_q;
  state_t           state_d;
  logic [TW-1:0]    fill_q;
  logic [TW-1:0]    fill_d;
  logic [WIDTH-1:0] window_q;
  logic [WIDTH-1:0] window_d;
  logic [WIDTH-1:0] window_next;
  logic [WIDTH-1:0] agree;
  logic [TW-1:0]    score_next;
  logic             match_next;
  logic             produce;

  // ---------------------------------------------------------------------------
  // Scoring datapath. The window after the shift is scored, so the result
  // always reflects the bit accepted on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    window_next = {window_q[WIDTH-2:0], in_bit};
    agree       = ~(window_next ^ pattern);
    score_next  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      score_next = score_next + TW'(agree[i]);
    end
    match_next = (score_next >= threshold);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. clear takes priority over in_valid, so a bit that
  // arrives together with clear is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    window_d = window_q;
    produce  = 1'b0;
    if (clear) begin
      state_d  = FILL;
      fill_d   = '0;
      window_d = '0;
    end else if (in_valid) begin
      window_d = window_next;
      case (state_q)
        FILL: begin
          // The bit that completes the window is scored immediately.
          if (fill_q == TW'(WIDTH - 1)) begin
            state_d = RUN;
            fill_d  = TW'(WIDTH);
            produce = 1'b1;
          end else begin
            fill_d = fill_q + TW'(1);
          end
        end
        RUN: begin
          produce = 1'b1;
        end
        default: begin
          state_d = FILL;
          fill_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      fill_q    <= '0;
      window_q  <= '0;
      out_valid <= 1'b0;
      match     <= 1'b0;
      score     <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      window_q  <= window_d;
      out_valid <= produce;
      match     <= produce & match_next;
      if (clear) begin
        score <= '0;
      end else if (produce) begin
        score <= score_next;
      end
    end
  end

`ifdef MATCH_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating match counter. It counts the registered match pulses, so it
  // trails the match output by one cycle. clear wins over a pending count.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (out_valid && match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_serial_xnor_correlator.sv
// -----------------------------------------------------------------------------
// tb_serial_xnor_correlator
//
// Directed and random stimulus for serial_xnor_correlator (WIDTH=8, CNT_W=2).
// A behavioural model keeps the bits accepted since the last clear in a queue
// and scores the last WIDTH of them arithmetically against the pattern.
// -----------------------------------------------------------------------------
module tb_serial_xnor_correlator;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int TW    = $clog2(WIDTH + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [TW-1:0]    threshold = '0;
  logic             out_valid;
  logic [TW-1:0]    score;
  logic             match;
  logic [CNT_W-1:0] match_count;

  always #5 clk = ~clk;

  serial_xnor_correlator #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .clear      (clear),
    .pattern    (pattern),
    .threshold  (threshold),
    .out_valid  (out_valid),
    .score      (score),
    .match      (match),
    .match_count(match_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model state
  // ---------------------------------------------------------------------------
  int         total = 0;
  int         bad   = 0;
  logic [0:0] hist_q[$];     // accepted bits since last clear, oldest first
  logic       exp_valid = 1'b0;
  logic       exp_match = 1'b0;
  int         exp_score = 0;
  int         exp_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"},   32'(out_valid),   32'(exp_valid));
    chk({tag, ".score"},       32'(score),       32'(exp_score));
    chk({tag, ".match"},       32'(match),       32'(exp_match));
    chk({tag, ".match_count"}, 32'(match_count), 32'(exp_cnt));
  endtask

  task automatic model_reset();
    hist_q.delete();
    exp_valid = 1'b0;
    exp_match = 1'b0;
    exp_score = 0;
    exp_cnt   = 0;
  endtask

  // Predict registered outputs after one rising edge with the given inputs.
  task automatic model_edge(input logic v, input logic b, input logic c,
                            input logic [WIDTH-1:0] pat, input int thr);
    int win;
    int agree_n;
`ifdef MATCH_CNT_EN
    if (c) exp_cnt = 0;
    else if (exp_valid && exp_match && exp_cnt < (1 << CNT_W) - 1) exp_cnt = exp_cnt + 1;
`else
    exp_cnt = 0;
`endif
    if (c) begin
      hist_q.delete();
      exp_valid = 1'b0;
      exp_match = 1'b0;
      exp_score = 0;
    end else if (v) begin
      hist_q.push_back(b);
      if (hist_q.size() > WIDTH) void'(hist_q.pop_front());
      if (hist_q.size() == WIDTH) begin
        win = 0;
        for (int k = 0; k < WIDTH; k++) win = win * 2 + int'(hist_q[k]);
        agree_n = 0;
        for (int k = 0; k < WIDTH; k++)
          if (((win >> k) & 1) == ((int'(pat) >> k) & 1)) agree_n++;
        exp_score = agree_n;
        exp_valid = 1'b1;
        exp_match = (agree_n >= thr);
      end else begin
        exp_valid = 1'b0;
        exp_match = 1'b0;
      end
    end else begin
      exp_valid = 1'b0;
      exp_match = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change on the falling edge, outputs sampled #1 after
  // the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input string tag, input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    clear    = c;
    @(posedge clk);
    model_edge(v, b, c, pattern, int'(threshold));
    #1;
    check_outputs(tag);
  endtask

  task automatic feed_word(input string tag, input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) step(tag, 1'b1, w[i], 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence followed by random traffic
  // ---------------------------------------------------------------------------
  initial begin
    logic [WIDTH-1:0] w;

    // Reset held low with random inputs.
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_bit    = 1'($urandom);
      clear     = 1'($urandom);
      pattern   = WIDTH'($urandom);
      threshold = TW'($urandom);
      @(posedge clk);
      #1;
      check_outputs("reset");
    end
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b1;

    // Exact sync word, threshold = WIDTH.
    pattern   = 8'hA5;
    threshold = TW'(8);
    feed_word("exact", 8'hA5);

    // Partial matches against the same pattern, threshold 6.
    threshold = TW'(6);
    step("clr1", 1'b0, 1'b0, 1'b1);
    feed_word("a4", 8'hA4);
    step("clr2", 1'b0, 1'b0, 1'b1);
    feed_word("a0", 8'hA0);
    step("clr3", 1'b0, 1'b0, 1'b1);
    feed_word("zero", 8'h00);

    // Clear together with in_valid drops the bit and refills from empty.
    step("clr4", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("part", 1'b1, 1'($urandom), 1'b0);
    step("clr_v", 1'b1, 1'b1, 1'b1);
    feed_word("refill", 8'hA5);

    // Gaps in RUN: score holds, then one more bit shifts the window.
    for (int i = 0; i < 5; i++) step("gap", 1'b0, 1'($urandom), 1'b0);
    step("shift", 1'b1, 1'b1, 1'b0);

    // threshold above WIDTH never matches.
    threshold = TW'(9);
    for (int i = 0; i < 4; i++) step("thr_hi", 1'b1, 1'($urandom), 1'b0);
    threshold = '1;
    feed_word("thr_max", 8'hA5);

    // threshold 0 always matches; counter saturation and clear.
    threshold = '0;
    step("clr5", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step("sat", 1'b1, 1'($urandom), 1'b0);
    step("sat_tail", 1'b0, 1'b0, 1'b0);
    step("sat_tail2", 1'b0, 1'b0, 1'b0);
    step("clr6", 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream.
    threshold = TW'(4);
    feed_word("pre_rst", 8'h3C);
    step("pre_rst2", 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step("post_rst", 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional pattern/threshold changes and clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) pattern = WIDTH'($urandom);
      if ($urandom_range(0, 15) == 0) threshold = TW'($urandom_range(0, 10));
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom_range(0, 40) == 0);
    end

    // Directed value check independent of the model path.
    step("clr7", 1'b0, 1'b0, 1'b1);
    pattern   = 8'hA5;
    threshold = TW'(3);
    w = 8'hA5;
    feed_word("final", w);
    step("final_shift", 1'b1, 1'b1, 1'b0);
    chk("window_4b_score", 32'(score), 32'd2);
    chk("window_4b_match", 32'(match), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
